cdb_broadcaster: RTL

Complete-stage block that drives the common data bus (CDB) consumed by every RS entry, the map table and the ROB.
- Collects finished results from NUM_FU functional units over a valid/ready handshake.
- Holds each result in a per-FU one-entry buffer.
- Broadcasts at most one {tag, value} per cycle, chosen by round-robin arbitration.
- Encodes "no broadcast" as tag 0, which RS entries treat as a non-match.

---
 rtl/cdb_broadcaster_pkg.sv | 21 ++
 rtl/cdb_broadcaster_if.sv | 25 ++
 rtl/cdb_broadcaster_rr_arbiter.sv | 29 ++
 rtl/cdb_broadcaster.sv | 76 +++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB types and sizing for the complete stage.
// RS entries, the map table and the ROB import the same definitions.
package cdb_broadcaster_pkg;
  localparam int NUM_FU = 4;
  localparam int TAG_W  = 5;
  localparam int XLEN   = 32;
  localparam int IDX_W  = $clog2(NUM_FU);

  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  typedef struct packed {
    logic [TAG_W-1:0] reg_tag;
    logic [XLEN-1:0]  reg_value;
  } cdb_packet_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } fu_result_t;
endpackage

// File: rtl/cdb_broadcaster_if.sv
// FU completion ports plus CDB broadcast bus.
// The master side is the FU cluster and the CDB consumers; the slave side is the broadcaster.
interface cdb_broadcaster_if;
  import cdb_broadcaster_pkg::*;

  logic [NUM_FU-1:0]            fu_valid;
  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_value;
  logic [NUM_FU-1:0]            fu_ready;
  logic                         squash;
  logic                         cdb_valid;
  logic [TAG_W-1:0]             cdb_tag;
  logic [XLEN-1:0]              cdb_value;
  logic [IDX_W-1:0]             cdb_grant_idx;

  modport master (
    output fu_valid, fu_tag, fu_value, squash,
    input  fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_grant_idx
  );

  modport slave (
    input  fu_valid, fu_tag, fu_value, squash,
    output fu_ready, cdb_valid, cdb_tag, cdb_value, cdb_grant_idx
  );
endinterface

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin picker: the first set req at or after rr_ptr wins, wrapping.
module cdb_rr_arbiter
  import cdb_broadcaster_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);
  // Scan from the farthest slot back to rr_ptr so the nearest requester is written last.
  always_comb begin : p_scan
    int j;
    j         = 0;
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        grant     = '0;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/cdb_broadcaster.sv
// Complete stage: per-FU one-entry result buffers drained onto a registered CDB,
// one broadcast per cycle, round-robin across FUs.
module cdb_broadcaster
  import cdb_broadcaster_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  cdb_broadcaster_if.slave bus
);
  fu_result_t [NUM_FU-1:0] bufs;
  logic [NUM_FU-1:0]       req, grant, ready;
  logic [IDX_W-1:0]        rr_ptr, grant_idx;

  cdb_packet_t             cdb_q;
  logic                    cdb_vld_q;
  logic [IDX_W-1:0]        cdb_idx_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_req
    assign req[i] = bufs[i].valid;
  end

  cdb_rr_arbiter #(.N(NUM_FU)) u_arb (
    .req       (req),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // A draining buffer can refill at the same edge, so an uncontended FU streams at full rate.
  assign ready        = ~req | grant;
  assign bus.fu_ready = ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bufs      <= '0;
      rr_ptr    <= '0;
      cdb_q     <= '0;
      cdb_vld_q <= 1'b0;
      cdb_idx_q <= '0;
    end else if (bus.squash) begin
      for (int i = 0; i < NUM_FU; i++) bufs[i].valid <= 1'b0;
      cdb_q     <= '0;
      cdb_vld_q <= 1'b0;
      cdb_idx_q <= '0;
    end else begin
      cdb_q     <= '0;
      cdb_vld_q <= 1'b0;
      cdb_idx_q <= '0;
      if (|grant) begin
        bufs[grant_idx].valid <= 1'b0;
        rr_ptr <= (grant_idx == IDX_W'(NUM_FU - 1)) ? '0 : IDX_W'(grant_idx + 1'b1);
        // A null tag would alias "no broadcast" on the bus, so it is dropped silently.
        if (bufs[grant_idx].tag != NULL_TAG) begin
          cdb_vld_q       <= 1'b1;
          cdb_q.reg_tag   <= bufs[grant_idx].tag;
          cdb_q.reg_value <= bufs[grant_idx].value;
          cdb_idx_q       <= grant_idx;
        end
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (bus.fu_valid[i] && ready[i])
          bufs[i] <= '{valid: 1'b1, tag: bus.fu_tag[i], value: bus.fu_value[i]};
      end
    end
  end

  assign bus.cdb_valid     = cdb_vld_q;
  assign bus.cdb_tag       = cdb_q.reg_tag;
  assign bus.cdb_value     = cdb_q.reg_value;
  assign bus.cdb_grant_idx = cdb_idx_q;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_chk
    a_tag_nonnull: assert property (@(posedge clock) disable iff (reset)
      bus.fu_valid[i] |-> bus.fu_tag[i] != NULL_TAG);
  end
endmodule
